// File: rtl/led_pkg.sv
// Shared constants and types for the LED output path (blinker and fade/PWM stage).
package led_pkg;

  localparam int unsigned DEF_PWM_BITS = 8;
  // ~1 s full 0..255 ramp at 100 MHz; the blinker uses the same step period.
  localparam int unsigned DEF_STEP_DIV = 390625;

  typedef logic [DEF_PWM_BITS-1:0] led_level_t;

  function automatic int unsigned max_level(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  localparam led_level_t MAX_LEVEL = led_level_t'(max_level(DEF_PWM_BITS));

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating up/down brightness level and PWM compare.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                sys_rstn,
  input  logic                i_tick,
  input  logic                i_req,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_on
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(max_level(PWM_BITS));

  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_level_next;

  always_comb begin
    w_level_next = r_level;
    if (i_tick) begin
      if (i_req && (r_level != LVL_MAX)) begin
        w_level_next = r_level + PWM_BITS'(1);
      end else if (!i_req && (r_level != '0)) begin
        w_level_next = r_level - PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_level <= '0;
    end else begin
      r_level <= w_level_next;
    end
  end

  // pwm_cnt never reaches LVL_MAX, so full level gives a constant-on output.
  assign o_on = (r_level > i_pwm_cnt);

endmodule

// File: rtl/led_fade_pwm.sv
// LED output stage: per-channel linear fade in/out driven as PWM to the pins.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned N_LED    = 2,
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
  input  logic             clk,
  input  logic             sys_rstn,
  input  logic [N_LED-1:0] led_req,
  input  logic             enable,
  output logic [N_LED-1:0] led_out
);

  localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(max_level(PWM_BITS) - 1);

  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PRE_W-1:0]    w_pre_next;
  logic                w_step_tick;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] w_pwm_next;
  logic [N_LED-1:0]    w_on;
  logic [N_LED-1:0]    r_led_out;

  assign w_step_tick = (r_pre_cnt == PRE_LAST);

  always_comb begin
    w_pre_next = r_pre_cnt + PRE_W'(1);
    if (w_step_tick) begin
      w_pre_next = '0;
    end
    // Period is MAX_LEVEL cycles so that level k gives exactly k high cycles.
    w_pwm_next = r_pwm_cnt + PWM_BITS'(1);
    if (r_pwm_cnt == PWM_LAST) begin
      w_pwm_next = '0;
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
      r_led_out <= '0;
    end else begin
      r_pre_cnt <= w_pre_next;
      r_pwm_cnt <= w_pwm_next;
      r_led_out <= {N_LED{enable}} & w_on;
    end
  end

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk      (clk),
      .sys_rstn (sys_rstn),
      .i_tick   (w_step_tick),
      .i_req    (led_req[g]),
      .i_pwm_cnt(r_pwm_cnt),
      .o_on     (w_on[g])
    );
  end

  assign led_out = r_led_out;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm (PWM_BITS=3, STEP_DIV=4, N_LED=2) with a queued scoreboard.
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       sys_rstn;
  logic       enable;
  logic [1:0] led_req;
  logic [1:0] led_out;

  led_fade_pwm #(
    .N_LED   (2),
    .PWM_BITS(3),
    .STEP_DIV(4)
  ) dut (
    .clk     (clk),
    .sys_rstn(sys_rstn),
    .led_req (led_req),
    .enable  (enable),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  // Reference state: edges since reset release and per-channel brightness.
  int         m_cyc = 0;
  int         m_lvl[2] = '{0, 0};
  logic [1:0] m_last = '0;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: led_out=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already set; predicts led_out after the next edge.
  task automatic step(input string nm);
    exp_t e;
    int   pwm;
    e.name = nm;
    e.exp  = '0;
    if (!sys_rstn) begin
      m_cyc    = 0;
      m_lvl[0] = 0;
      m_lvl[1] = 0;
    end else begin
      pwm = m_cyc % 7;
      for (int i = 0; i < 2; i++) begin
        e.exp[i] = enable && (m_lvl[i] > pwm);
      end
      if (m_cyc % 4 == 3) begin
        for (int i = 0; i < 2; i++) begin
          if (led_req[i] && m_lvl[i] < 7) begin
            m_lvl[i]++;
          end else if (!led_req[i] && m_lvl[i] > 0) begin
            m_lvl[i]--;
          end
        end
      end
      m_cyc++;
    end
    m_last = e.exp;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input string nm, input int n);
    repeat (n) step(nm);
  endtask

  task automatic wait_lvl(input string nm, input int lvl, input bit need_on);
    int k = 0;
    while (!(m_lvl[0] == lvl && (!need_on || m_last != 2'b00)) && k < 100) begin
      step(nm);
      k++;
    end
    n_checks++;
    if (k >= 100) begin
      n_errors++;
      $display("FAIL %s: level %0d not reached, got %0d", nm, lvl, m_lvl[0]);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, led_out, e.exp);
      end
    end
  end

  initial begin
    sys_rstn = 1'b0;
    led_req  = 2'b11;
    enable   = 1'b1;
    @(negedge clk);

    // Reset holds outputs low despite requests, then idle stays dark.
    run("rst_hold", 5);
    chk("rst_state", led_out, 2'b00);
    led_req  = 2'b00;
    sys_rstn = 1'b1;
    run("idle", 1000);

    // Ramp channel 0 to full from release.
    sys_rstn = 1'b0;
    run("rst2", 2);
    sys_rstn = 1'b1;
    led_req  = 2'b01;
    run("ramp_up", 40);

    // Hover around level 3 by toggling the request at each tick.
    sys_rstn = 1'b0;
    run("rst3", 2);
    sys_rstn = 1'b1;
    led_req  = 2'b01;
    wait_lvl("to_lvl3", 3, 1'b0);
    for (int i = 0; i < 28; i++) begin
      if (m_cyc % 4 == 3) led_req[0] = (m_lvl[0] < 3);
      step("duty");
    end

    // Reverse mid-ramp and saturate at zero.
    led_req = 2'b01;
    wait_lvl("to_lvl5", 5, 1'b0);
    led_req = 2'b00;
    run("reverse", 50);

    // Output enable gating while levels keep moving.
    led_req = 2'b01;
    wait_lvl("to_lvl7", 7, 1'b0);
    run("full", 10);
    enable  = 1'b0;
    led_req = 2'b00;
    run("disabled", 12);
    enable = 1'b1;
    run("reenable", 30);

    // Asynchronous reset between edges while lit.
    sys_rstn = 1'b0;
    run("rst6", 2);
    sys_rstn = 1'b1;
    led_req  = 2'b11;
    wait_lvl("to_lvl4", 4, 1'b1);
    @(posedge clk);
    #2;
    sys_rstn = 1'b0;
    #1;
    chk("async_rst", led_out, 2'b00);
    @(negedge clk);
    run("in_rst", 3);
    sys_rstn = 1'b1;
    run("restart", 40);

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d pending, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
